wb_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 32-bit Wishbone slave (the memory-backed wishbone_slave)

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 35 +++
 rtl/wb_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the Wishbone round-robin arbiter.
package wb_arb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after 'last', wrapping N-1 -> 0.
// 'last' itself is searched at the end, so it has the lowest priority.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    // Scan offsets 1..N from last; the sum is below 2N, so one subtraction wraps it.
    always_comb begin
        logic [IW:0] pos;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = {1'b0, last} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!valid && req[pos[IW-1:0]]) begin
                gnt[pos[IW-1:0]] = 1'b1;
                idx              = pos[IW-1:0];
                valid            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave.
// Ownership lasts for a whole CYC; a watchdog ends stalled strobes with ERR.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_sel_i,
    input  logic [NUM_MASTERS*WB_AW-1:0]  m_adr_i,
    input  logic [NUM_MASTERS*WB_DW-1:0]  m_dat_i,
    output logic [WB_DW-1:0]              m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [NUM_MASTERS-1:0]        gnt_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic                          s_sel_o,
    output logic [WB_AW-1:0]              s_adr_o,
    output logic [WB_DW-1:0]              s_dat_o,
    input  logic [WB_DW-1:0]              s_dat_i,
    input  logic                          s_ack_i
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   own;
    logic [WW-1:0]   wdog;

    logic [NUM_MASTERS-1:0] pick_oh;
    logic [IW-1:0]          pick_idx;
    logic                   pick_vld;

    logic [WB_AW-1:0] adr_arr [NUM_MASTERS];
    logic [WB_DW-1:0] dat_arr [NUM_MASTERS];

    logic busy;
    logic own_cyc;
    logic own_stb;
    logic expired;

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_split
        assign adr_arr[k] = m_adr_i[k*WB_AW +: WB_AW];
        assign dat_arr[k] = m_dat_i[k*WB_DW +: WB_DW];
    end

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req   (m_cyc_i),
        .last  (last),
        .gnt   (pick_oh),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign busy    = (state == BUSY);
    assign own_cyc = m_cyc_i[own];
    assign own_stb = m_stb_i[own];
    // An ACK arriving in the expiry cycle still completes the transfer normally.
    assign expired = busy && (wdog == WW'(TIMEOUT)) && !s_ack_i;

    // Grant FSM, round-robin pointer and stall watchdog.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= IDLE;
            gnt_o <= '0;
            last  <= IW'(NUM_MASTERS - 1);
            own   <= '0;
            wdog  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (pick_vld) begin
                        gnt_o <= pick_oh;
                        own   <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_cyc || expired) begin
                        // Owner drops to lowest priority; the dead cycle in IDLE re-arbitrates.
                        state <= IDLE;
                        gnt_o <= '0;
                        last  <= own;
                        wdog  <= '0;
                    end else if (own_stb && !s_ack_i) begin
                        wdog <= wdog + 1'b1;
                    end else begin
                        wdog <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_o <= '0;
                    wdog  <= '0;
                end
            endcase
        end
    end

    // Route the owner to the slave and the slave response back to the owner only.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (busy && !RST_I) begin
            s_cyc_o      = own_cyc && !expired;
            s_stb_o      = own_stb && !expired;
            s_we_o       = m_we_i[own];
            s_sel_o      = m_sel_i[own];
            s_adr_o      = adr_arr[own];
            s_dat_o      = dat_arr[own];
            m_ack_o[own] = s_ack_i;
            m_err_o[own] = expired;
        end
    end

    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: grant-order table, directed corner sequences,
// and randomized traffic checked every cycle against a behavioural model.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           CLK_I = 1'b0;
    logic           RST_I = 1'b1;
    logic [N-1:0]   m_cyc_i, m_stb_i, m_we_i, m_sel_i;
    logic [N*32-1:0] m_adr_i, m_dat_i;
    logic [31:0]    m_dat_o;
    logic [N-1:0]   m_ack_o, m_err_o, gnt_o;
    logic           s_cyc_o, s_stb_o, s_we_o, s_sel_o;
    logic [31:0]    s_adr_o, s_dat_o, s_dat_i;
    logic           s_ack_i;

    // Slave: memory with a programmable number of wait states, or random responses.
    bit          use_slave = 1'b1;
    int          slv_delay = 0;
    int          slv_cnt   = 0;
    bit [31:0]   mem [256];
    logic        slv_ack;
    logic        rand_ack  = 1'b0;
    logic [31:0] rand_dat  = '0;

    assign slv_ack = s_cyc_o && s_stb_o && (slv_cnt == slv_delay);
    assign s_ack_i = use_slave ? slv_ack : rand_ack;
    assign s_dat_i = use_slave ? mem[s_adr_o[9:2]] : rand_dat;

    always @(posedge CLK_I) begin
        if (s_cyc_o && s_stb_o && !slv_ack) slv_cnt <= slv_cnt + 1;
        else                                slv_cnt <= 0;
        if (use_slave && slv_ack && s_we_o) mem[s_adr_o[9:2]] <= s_dat_o;
    end

    always #5 CLK_I = ~CLK_I;

    wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .gnt_o(gnt_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    // Behavioural model: who owns the bus, who won last, how long the strobe has stalled.
    int mo_own  = -1;
    int mo_last = N - 1;
    int mo_wd   = 0;

    function automatic int rr_win(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] e_gnt = '0, e_ack = '0, e_err = '0;
        logic e_cyc = 0, e_stb = 0, e_we = 0, e_sel = 0;
        logic [31:0] e_adr = '0, e_dat = '0;
        bit to = 1'b0;
        int w;
        if (mo_own >= 0) begin
            to = (mo_wd == TO) && !s_ack_i;
            e_gnt[mo_own] = 1'b1;
            e_cyc = m_cyc_i[mo_own] && !to;
            e_stb = m_stb_i[mo_own] && !to;
            e_we  = m_we_i[mo_own];
            e_sel = m_sel_i[mo_own];
            e_adr = m_adr_i[mo_own*32 +: 32];
            e_dat = m_dat_i[mo_own*32 +: 32];
            e_ack[mo_own] = s_ack_i;
            e_err[mo_own] = to;
        end
        chk("model_ctl", {gnt_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o},
                         {e_gnt, e_ack, e_err, e_cyc, e_stb, e_we, e_sel});
        chk("model_bus", {s_adr_o, s_dat_o}, {e_adr, e_dat});
        chk("model_rdat", m_dat_o, s_dat_i);
        if (mo_own < 0) begin
            w = rr_win(m_cyc_i, mo_last);
            if (w >= 0) begin mo_own = w; mo_wd = 0; end
        end else if (!m_cyc_i[mo_own] || to) begin
            mo_last = mo_own; mo_own = -1; mo_wd = 0;
        end else if (m_stb_i[mo_own] && !s_ack_i) begin
            mo_wd++;
        end else begin
            mo_wd = 0;
        end
    endtask

    task automatic settle(); #1; endtask
    task automatic cyc_end(); model_step(); @(posedge CLK_I); #1; endtask

    task automatic model_reset(); mo_own = -1; mo_last = N - 1; mo_wd = 0; endtask

    task automatic do_reset();
        RST_I = 1'b1;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
        m_adr_i = '0; m_dat_i = '0; rand_ack = 1'b0; rand_dat = '0;
        @(posedge CLK_I); #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_bus", {s_cyc_o, s_stb_o, m_ack_o, m_err_o}, 0);
        RST_I = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0]    mask;
        bit              rereq;
        int              n;
        logic [4:0][1:0] ord;
    } rr_vec_t;

    // Masters in mask request together; each does one transfer then drops CYC
    // (and re-raises it a cycle later when rereq is set). Grants must follow ord.
    task automatic rr_run(input rr_vec_t v, input string nm);
        int k = 0, gap = 0, cyc = 0;
        logic [N-1:0] prev_gnt = '0, drop = '0, ack;
        use_slave = 1'b1; slv_delay = 0;
        m_cyc_i = v.mask; m_stb_i = v.mask; m_we_i = '0;
        while (k < v.n && cyc < 100) begin
            settle();
            if (gnt_o != 0 && gnt_o != prev_gnt) begin
                chk({nm, "_order"}, gnt_o, 4'b0001 << v.ord[k]);
                if (k > 0) chk({nm, "_gap"}, gap, 1);
                k++; gap = 0;
            end else if (gnt_o == 0) begin
                gap++;
            end
            prev_gnt = gnt_o; ack = m_ack_o;
            cyc_end(); cyc++;
            m_cyc_i = (m_cyc_i & ~ack) | (v.rereq ? drop : '0);
            m_stb_i = m_cyc_i;
            drop    = ack;
        end
        chk({nm, "_done"}, k, v.n);
        m_cyc_i = '0; m_stb_i = '0;
        settle(); cyc_end();
    endtask

    rr_vec_t tbl[5];

    initial begin
        int acks, bad1, gnt_ok, errs, cycles, n_to;

        tbl[0] = '{mask: 4'b1111, rereq: 1'b1, n: 5, ord: {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{mask: 4'b1010, rereq: 1'b0, n: 2, ord: {2'd0, 2'd0, 2'd0, 2'd3, 2'd1}};
        tbl[2] = '{mask: 4'b1000, rereq: 1'b0, n: 1, ord: {2'd0, 2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[3] = '{mask: 4'b0110, rereq: 1'b0, n: 2, ord: {2'd0, 2'd0, 2'd0, 2'd2, 2'd1}};
        tbl[4] = '{mask: 4'b1001, rereq: 1'b1, n: 4, ord: {2'd0, 2'd3, 2'd0, 2'd3, 2'd0}};

        // Single master write then read-back through the memory slave.
        do_reset();
        use_slave = 1'b1; slv_delay = 0;
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001; m_we_i = 4'b0001; m_sel_i = 4'b0001;
        m_adr_i[31:0] = 32'h10; m_dat_i[31:0] = 32'hDEADBEEF;
        settle(); chk("wr_gnt_idle", gnt_o, 0); cyc_end();
        settle(); chk("wr_gnt", gnt_o, 4'b0001); chk("wr_ack", m_ack_o, 4'b0001); cyc_end();
        m_we_i = '0; m_dat_i[31:0] = '0;
        settle(); chk("rd_ack", m_ack_o, 4'b0001); chk("rd_data", m_dat_o, 32'hDEADBEEF); cyc_end();
        m_cyc_i = '0; m_stb_i = '0;
        settle(); cyc_end();

        // Grant-order table, each from reset.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            rr_run(tbl[i], $sformatf("rr%0d", i));
        end

        // Master 2 holds CYC over three reads; master 1 waits.
        do_reset();
        slv_delay = 1;
        m_cyc_i = 4'b0100; m_stb_i = 4'b0100; m_adr_i[2*32 +: 32] = 32'h10;
        settle(); cyc_end();
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        acks = 0; bad1 = 0; gnt_ok = 1; cycles = 0;
        while (acks < 3 && cycles < 50) begin
            settle();
            if (m_ack_o[1]) bad1 = 1;
            if (gnt_o != 4'b0100) gnt_ok = 0;
            if (m_ack_o[2]) acks++;
            cyc_end(); cycles++;
        end
        chk("hold_acks2", acks, 3);
        chk("hold_noack1", bad1, 0);
        chk("hold_gnt2", gnt_ok, 1);
        m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0;
        settle(); chk("hold_rel", gnt_o, 4'b0100); cyc_end();
        settle(); chk("hold_dead", gnt_o, 0); cyc_end();
        settle(); chk("hold_gnt1", gnt_o, 4'b0010); cyc_end();
        m_cyc_i = '0; m_stb_i = '0;
        settle(); cyc_end();

        // Slave never acks: ERR in the 17th strobe cycle, then master 1 outranks master 2.
        do_reset();
        slv_delay = 1000;
        m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
        settle(); cyc_end();
        errs = 0;
        for (int k = 1; k <= TO; k++) begin
            settle();
            if (m_err_o != 0 || !s_stb_o) errs++;
            cyc_end();
        end
        chk("to_early", errs, 0);
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        settle();
        chk("to_err", m_err_o, 4'b0100);
        chk("to_stb", {s_cyc_o, s_stb_o}, 0);
        cyc_end();
        settle(); chk("to_idle", gnt_o, 0); cyc_end();
        settle(); chk("to_regrant", gnt_o, 4'b0010); cyc_end();
        m_cyc_i = '0; m_stb_i = '0;
        settle(); cyc_end();

        // ACK lands exactly when the watchdog reaches TIMEOUT.
        do_reset();
        slv_delay = TO;
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        settle(); cyc_end();
        errs = 0;
        for (int k = 1; k <= TO; k++) begin
            settle();
            if (m_ack_o != 0 || m_err_o != 0) errs++;
            cyc_end();
        end
        chk("ackto_early", errs, 0);
        settle(); chk("ackto_ack", m_ack_o, 4'b0001); chk("ackto_noerr", m_err_o, 0); cyc_end();
        m_cyc_i = '0; m_stb_i = '0;
        settle(); cyc_end();

        // Reset asserted between edges in the middle of a write.
        do_reset();
        slv_delay = 1000;
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001; m_we_i = 4'b0001;
        m_adr_i[31:0] = 32'h20; m_dat_i[31:0] = 32'h12345678;
        settle(); cyc_end();
        settle(); chk("mid_pre", {gnt_o, s_cyc_o}, {4'b0001, 1'b1}); cyc_end();
        #3; RST_I = 1'b1; #1;
        chk("mid_rst_bus", {s_cyc_o, s_stb_o, m_ack_o, m_err_o}, 0);
        chk("mid_rst_gnt", gnt_o, 0);
        @(posedge CLK_I); #1;
        RST_I = 1'b0; model_reset();
        m_cyc_i = 4'b1111; m_stb_i = 4'b1111; m_we_i = '0;
        settle(); cyc_end();
        settle(); chk("mid_first", gnt_o, 4'b0001); cyc_end();
        m_cyc_i = '0; m_stb_i = '0;
        settle(); cyc_end();
        settle(); cyc_end();

        // Randomized traffic with sticky CYC levels and random slave responses.
        do_reset();
        use_slave = 1'b0;
        n_to = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < N; m++) begin
                if ($urandom_range(0, 31) == 0) m_cyc_i[m] = ~m_cyc_i[m];
                m_stb_i[m] = ($urandom_range(0, 15) != 0);
                m_we_i[m]  = 1'($urandom_range(0, 1));
                m_sel_i[m] = 1'($urandom_range(0, 1));
                m_adr_i[m*32 +: 32] = $urandom;
                m_dat_i[m*32 +: 32] = $urandom;
            end
            rand_ack = ($urandom_range(0, 15) == 0);
            rand_dat = $urandom;
            settle();
            if (m_err_o != 0) n_to++;
            cyc_end();
        end
        chk("rand_timeouts_seen", (n_to > 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

endmodule
